// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out valid-ready bus for imm_gen_pipe
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag
  );
  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with two-entry skid buffer; IMM_ZICSR_EN adds CSR uimm (Z) decode
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic clk,
  input logic reset,
  imm_gen_pipe_if.slave bus
);
  localparam logic [2:0] F_I = 3'd0, F_S = 3'd1, F_B = 3'd2, F_U = 3'd3, F_J = 3'd4, F_Z = 3'd5, F_NONE = 3'd7;
  logic [31:0] inst;
  logic [6:0] op;
  logic [2:0] f3;
  logic shift;
  logic [31:0] raw;
  logic [2:0] fmt;
  logic [XLEN-1:0] imm;
  logic main_v, skid_v, rdy, acc, drn, skid_n;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic [2:0] main_fmt, skid_fmt;
  logic [TAG_W-1:0] main_tag, skid_tag;
  assign inst  = bus.in_inst;
  assign op    = inst[6:0];
  assign f3    = inst[14:12];
  assign shift = f3 == 3'b001 || f3 == 3'b101;
  // raw is a 32-bit signed immediate; zero-extended fields keep raw[31]=0 so one sign cast widens all
  always_comb begin
    raw = '0;
    fmt = F_NONE;
    case (op)
      7'b0000011, 7'b1100111: begin
        raw = {{20{inst[31]}}, inst[31:20]};
        fmt = F_I;
      end
      7'b0010011: begin
        raw = shift ? {26'd0, (XLEN == 64) ? inst[25] : 1'b0, inst[24:20]} : {{20{inst[31]}}, inst[31:20]};
        fmt = F_I;
      end
      7'b0011011: begin
        raw = (XLEN == 64) ? (shift ? {27'd0, inst[24:20]} : {{20{inst[31]}}, inst[31:20]}) : 32'd0;
        fmt = (XLEN == 64) ? F_I : F_NONE;
      end
      7'b0100011: begin
        raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        fmt = F_S;
      end
      7'b1100011: begin
        raw = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        fmt = F_B;
      end
      7'b0110111, 7'b0010111: begin
        raw = {inst[31:12], 12'h000};
        fmt = F_U;
      end
      7'b1101111: begin
        raw = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        fmt = F_J;
      end
`ifdef IMM_ZICSR_EN
      7'b1110011: begin
        raw = (f3[2] && f3[1:0] != 2'b00) ? {27'd0, inst[19:15]} : 32'd0;
        fmt = (f3[2] && f3[1:0] != 2'b00) ? F_Z : F_NONE;
      end
`endif
      default: ;
    endcase
  end
  assign imm = XLEN'($signed(raw));
  assign acc = bus.in_valid && rdy;
  assign drn = main_v && bus.out_ready;
  // skid only fills when main stays occupied; a drain always empties it into main
  assign skid_n = (acc && main_v && !drn) ? 1'b1 : (drn ? 1'b0 : skid_v);
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      rdy      <= 1'b0;
      main_imm <= '0;
      main_fmt <= F_NONE;
      main_tag <= '0;
      skid_imm <= '0;
      skid_fmt <= F_NONE;
      skid_tag <= '0;
    end else begin
      main_v <= acc || skid_v || (main_v && !drn);
      skid_v <= skid_n;
      rdy    <= !skid_n;
      if (drn && skid_v) begin
        main_imm <= skid_imm;
        main_fmt <= skid_fmt;
        main_tag <= skid_tag;
      end else if (acc && (!main_v || drn)) begin
        main_imm <= imm;
        main_fmt <= fmt;
        main_tag <= bus.in_tag;
      end
      if (acc && main_v && !drn) begin
        skid_imm <= imm;
        skid_fmt <= fmt;
        skid_tag <= bus.in_tag;
      end
    end
  end
  assign bus.in_ready  = rdy;
  assign bus.out_valid = main_v;
  assign bus.out_imm   = main_imm;
  assign bus.out_fmt   = main_fmt;
  assign bus.out_tag   = main_tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep, checked against a FIFO + decode-rule model
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_tag = '0;
  int tests = 0;
  int fails = 0;
  typedef struct {logic [31:0] inst; logic [31:0] tag;} ent_t;
  ent_t q[$];
  bit started = 1'b0;
  bit rst_prev = 1'b1;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();
  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) d32 (.clk(clk), .reset(reset), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) d64 (.clk(clk), .reset(reset), .bus(b64));
  assign b32.in_valid  = in_valid;
  assign b32.in_inst   = in_inst;
  assign b32.in_tag    = in_tag;
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.in_inst   = in_inst;
  assign b64.in_tag    = in_tag;
  assign b64.out_ready = out_ready;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] i, input bit x64, output logic [63:0] imm, output logic [2:0] fmt);
    logic [6:0] op;
    logic [2:0] f3;
    bit sh;
    longint v;
    op = i[6:0];
    f3 = i[14:12];
    sh = (f3 == 3'd1 || f3 == 3'd5);
    v = 0;
    fmt = 3'd7;
    if (op == 7'h03 || op == 7'h67 || (op == 7'h13 && !sh) || (op == 7'h1B && x64 && !sh)) begin
      fmt = 3'd0; v = longint'($signed(i[31:20]));
    end else if (op == 7'h13) begin
      fmt = 3'd0; v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
    end else if (op == 7'h1B && x64) begin
      fmt = 3'd0; v = longint'(i[24:20]);
    end else if (op == 7'h23) begin
      fmt = 3'd1; v = longint'($signed({i[31:25], i[11:7]}));
    end else if (op == 7'h63) begin
      fmt = 3'd2; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    end else if (op == 7'h37 || op == 7'h17) begin
      fmt = 3'd3; v = longint'($signed({i[31:12], 12'h000}));
    end else if (op == 7'h6F) begin
      fmt = 3'd4; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    end
`ifdef IMM_ZICSR_EN
    else if (op == 7'h73 && f3 >= 3'd5) begin
      fmt = 3'd5; v = longint'(i[19:15]);
    end
`endif
    imm = x64 ? v : {32'h0, v[31:0]};
  endfunction

  task automatic pin(input logic [31:0] i, input bit x64, input logic [63:0] ei, input logic [2:0] ef);
    logic [63:0] mi;
    logic [2:0] mf;
    ref_dec(i, x64, mi, mf);
    chk("pin_imm", mi, ei);
    chk("pin_fmt", {61'd0, mf}, {61'd0, ef});
  endtask

  always @(negedge clk) begin
    logic [63:0] ei;
    logic [2:0] ef;
    bit exp_rdy;
    exp_rdy = !rst_prev && q.size() < 2;
    if (started) begin
      chk("in_ready32", {63'd0, b32.in_ready}, {63'd0, exp_rdy});
      chk("in_ready64", {63'd0, b64.in_ready}, {63'd0, exp_rdy});
      chk("out_valid32", {63'd0, b32.out_valid}, {63'd0, q.size() != 0});
      chk("out_valid64", {63'd0, b64.out_valid}, {63'd0, q.size() != 0});
      if (q.size() != 0) begin
        ref_dec(q[0].inst, 1'b0, ei, ef);
        chk("imm32", {32'd0, b32.out_imm}, ei);
        chk("fmt32", {61'd0, b32.out_fmt}, {61'd0, ef});
        chk("tag32", {32'd0, b32.out_tag}, {32'd0, q[0].tag});
        ref_dec(q[0].inst, 1'b1, ei, ef);
        chk("imm64", b64.out_imm, ei);
        chk("fmt64", {61'd0, b64.out_fmt}, {61'd0, ef});
        chk("tag64", {32'd0, b64.out_tag}, {32'd0, q[0].tag});
      end else if (rst_prev) begin
        chk("rst_imm64", b64.out_imm, 64'd0);
        chk("rst_fmt32", {61'd0, b32.out_fmt}, 64'd7);
        chk("rst_tag32", {32'd0, b32.out_tag}, 64'd0);
      end
    end
    if (reset) begin
      q.delete();
      rst_prev = 1'b1;
      started = 1'b1;
    end else if (started) begin
      rst_prev = 1'b0;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) q.push_back('{in_inst, in_tag});
    end
  end

  task automatic send(input logic [31:0] i, input logic [31:0] t);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_inst = i;
    in_tag = t;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = b32.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: inst %h never accepted", i);
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] vecs [12] = '{32'hFFF00093, 32'hFE000EE3, 32'hFF9FF06F, 32'h123452B7,
                             32'h02109093, 32'h3002D073, 32'h0000007F, 32'h4010D093,
                             32'hFFF0809B, 32'h0210909B, 32'hFE20AE23, 32'h800000B7};
  logic [31:0] bp [3] = '{32'hFFF03093, 32'h30029073, 32'h00100097};

  initial begin
    int n;
    pin(32'hFFF00093, 1'b0, 64'h0000_0000_FFFF_FFFF, 3'd0);
    pin(32'hFE000EE3, 1'b0, 64'h0000_0000_FFFF_FFFC, 3'd2);
    pin(32'hFF9FF06F, 1'b0, 64'h0000_0000_FFFF_FFF8, 3'd4);
    pin(32'h123452B7, 1'b0, 64'h0000_0000_1234_5000, 3'd3);
    pin(32'h02109093, 1'b1, 64'h0000_0000_0000_0021, 3'd0);
    pin(32'hFFF00093, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0);
    pin(32'h0000007F, 1'b1, 64'd0, 3'd7);
`ifdef IMM_ZICSR_EN
    pin(32'h3002D073, 1'b0, 64'd5, 3'd5);
`else
    pin(32'h3002D073, 1'b0, 64'd0, 3'd7);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_low_after_reset", {63'd0, b32.in_ready}, 64'd0);
    @(negedge clk);
    chk("ready_high_after_reset", {63'd0, b32.in_ready}, 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    foreach (vecs[k]) send(vecs[k], 32'h100 + k);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_inst = bp[n];
      in_tag = 32'h200 + n;
      @(negedge clk);
      if (b32.in_ready) n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", 64'(n), 64'd2);
    @(negedge clk);
    chk("bp_ready_low", {63'd0, b32.in_ready}, 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_tag", {32'd0, b32.out_tag}, 64'h200);
    chk("bp_ready_still_low", {63'd0, b32.in_ready}, 64'd0);
    @(negedge clk);
    chk("bp_second_tag", {32'd0, b32.out_tag}, 64'h201);
    chk("bp_ready_back", {63'd0, b32.in_ready}, 64'd1);
    @(posedge clk);
    #1 send(bp[2], 32'h202);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'hFFF00093, 32'h300);
    send(32'h123452B7, 32'h301);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("flush_valid", {63'd0, b32.out_valid}, 64'd0);
    chk("flush_fmt", {61'd0, b64.out_fmt}, 64'd7);
    @(negedge clk);
    chk("flush_ready", {63'd0, b32.in_ready}, 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'hFE000EE3, 32'h400);
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
